// File: rtl/fifo_rd_packer.sv
// Read-domain consumer of the async FIFO: pops words, packs RATIO of them into one
// wide beat on a valid/ready stream, and flushes partial packs on timeout or request.
module fifo_rd_packer #(
  parameter int DSIZE   = 8,
  parameter int RATIO   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                   rclk,
  input  logic                   rrst,
  input  logic [DSIZE-1:0]       rdata,
  input  logic                   rempty,
  output logic                   rinc,
  input  logic                   flush,
  output logic [DSIZE*RATIO-1:0] out_data,
  output logic [RATIO-1:0]       out_keep,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy
);

  localparam int CW   = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int IW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TRIG = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  localparam logic [CW-1:0] LAST     = CW'(RATIO - 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT);
  localparam logic [IW-1:0] IDLE_TRG = IW'(TRIG);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCUM  = 2'd1;
  localparam logic [1:0] S_FLUSHW = 2'd2;

  logic [1:0]                   state;
  logic [CW-1:0]                pack_cnt;
  logic [IW-1:0]                idle_cnt;
  logic [DSIZE*(RATIO-1)-1:0]   pack_data;

  logic                         slot_free;
  logic                         pop;
  logic                         complete;
  logic                         timeout_hit;
  logic                         flush_go;
  logic [DSIZE*RATIO-1:0]       flush_data;
  logic [RATIO-1:0]             flush_keep;

  assign slot_free   = !out_valid || out_ready;
  assign rinc        = !rrst && !rempty && ((pack_cnt != LAST) || slot_free);
  assign pop         = rinc;
  assign complete    = pop && (pack_cnt == LAST);
  assign timeout_hit = (TIMEOUT != 0) && (idle_cnt == IDLE_TRG);
  assign flush_go    = (state == S_FLUSHW) && !pop && slot_free;
  assign busy        = (pack_cnt != '0) || out_valid;

  // Slots above pack_cnt may hold words of an earlier pack, so they are masked off.
  always_comb begin
    flush_data = '0;
    flush_keep = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (CW'(i) < pack_cnt) begin
        flush_keep[i] = 1'b1;
      end
    end
    for (int i = 0; i < RATIO - 1; i++) begin
      if (CW'(i) < pack_cnt) begin
        flush_data[i*DSIZE +: DSIZE] = pack_data[i*DSIZE +: DSIZE];
      end
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      pack_data <= '0;
    end else if (pop && !complete) begin
      for (int i = 0; i < RATIO - 1; i++) begin
        if (pack_cnt == CW'(i)) begin
          pack_data[i*DSIZE +: DSIZE] <= rdata;
        end
      end
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      pack_cnt <= '0;
      idle_cnt <= '0;
    end else begin
      if (complete || flush_go) begin
        pack_cnt <= '0;
      end else if (pop) begin
        pack_cnt <= pack_cnt + 1'b1;
      end
      if (pop || flush_go) begin
        idle_cnt <= '0;
      end else if ((state != S_IDLE) && (idle_cnt != IDLE_MAX)) begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

  // A pop always wins over a pending flush; the flush retries on the next idle cycle.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (complete) begin
            state <= S_IDLE;
          end else if (flush || (!pop && timeout_hit)) begin
            state <= S_FLUSHW;
          end
        end
        S_FLUSHW: begin
          if (complete || flush_go) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
    end else if (complete) begin
      out_valid <= 1'b1;
      out_data  <= {rdata, pack_data};
      out_keep  <= '1;
    end else if (flush_go) begin
      out_valid <= 1'b1;
      out_data  <= flush_data;
      out_keep  <= flush_keep;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
